frame_stats_reader: RTL and testbench

Bus-master block downstream of the camera grabber. It burst-reads the packed 8-bit grayscale frame buffer the grabber writes to memory and accumulates per-frame statistics: pixel sum, minimum, maximum and above-threshold count. Software controls it through a custom instruction, typically started after the grabber reports a single shot done.

---
 rtl/frame_stats_reader.sv | 187 ++++++++++++++++++
 tb/tb_frame_stats_reader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stats_reader.sv
// Custom-instruction controlled bus master: burst-reads a packed 8-bit grayscale frame and
// accumulates sum, min, max and above-threshold count. Optional feature: FRAME_STATS_THRESHOLD_EN.
module frame_stats_reader #(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  output logic        requestBus,
  input  logic        busGrant,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic        readNotWriteOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  output logic        endTransactionOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn
);

  typedef enum logic [2:0] {StIdle, StReq, StInit, StRead, StAbort, StNext} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_base, r_addr, r_sum, r_addr_out;
  logic [17:0] r_words, r_remaining;
  logic [7:0]  r_min, r_max, r_burst_out;
  logic        r_busy, r_done, r_error, r_begin;
  logic        w_sel, w_wr, w_accum;
  logic [2:0]  w_cmd;
  logic [4:0]  w_burst;
  logic [9:0]  w_word_sum;
  logic [7:0]  w_word_min, w_word_max;
  logic        w_unused;
`ifdef FRAME_STATS_THRESHOLD_EN
  logic [7:0]  r_thresh;
  logic [19:0] r_count;
  logic [2:0]  w_word_cnt;
`endif

  assign w_unused = ^ciValueA[31:3];
  assign w_sel    = ciStart & ciCke & (ciN == customInstructionId);
  assign ciDone   = w_sel;
  assign w_cmd    = ciValueA[2:0];
  assign w_wr     = w_sel & ~r_busy;
  assign w_burst  = (r_remaining > 18'd16) ? 5'd16 : r_remaining[4:0];
  // A word flagged with a bus error is dropped.
  assign w_accum  = (r_state == StRead) & dataValidIn & ~busErrorIn;

  assign requestBus          = (r_state == StReq);
  assign endTransactionOut   = (r_state == StAbort);
  assign beginTransactionOut = r_begin;
  assign readNotWriteOut     = r_begin;
  assign byteEnablesOut      = r_begin ? 4'hF : 4'h0;
  assign addressDataOut      = r_addr_out;
  assign burstSizeOut        = r_burst_out;

  always_comb begin
    w_word_sum = '0;
    w_word_min = 8'hFF;
    w_word_max = '0;
    for (int i = 0; i < 4; i++) begin
      w_word_sum = w_word_sum + {2'b00, addressDataIn[8*i +: 8]};
      if (addressDataIn[8*i +: 8] < w_word_min) w_word_min = addressDataIn[8*i +: 8];
      if (addressDataIn[8*i +: 8] > w_word_max) w_word_max = addressDataIn[8*i +: 8];
    end
  end

`ifdef FRAME_STATS_THRESHOLD_EN
  always_comb begin
    w_word_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (addressDataIn[8*i +: 8] > r_thresh) w_word_cnt = w_word_cnt + 3'd1;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_wr && (w_cmd == 3'd3) && (r_words != '0)) w_state_next = StReq;
      StReq:   if (busGrant) w_state_next = StInit;
      StInit:  w_state_next = StRead;
      StRead: begin
        if (busErrorIn)            w_state_next = StAbort;
        else if (endTransactionIn) w_state_next = StNext;
      end
      StAbort: w_state_next = StIdle;
      StNext:  w_state_next = (r_remaining != '0) ? StReq : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    ciResult = '0;
    if (w_sel) begin
      case (w_cmd)
        3'd4:    ciResult = {29'd0, r_error, r_done, r_busy};
        3'd5:    ciResult = r_sum;
        3'd6:    ciResult = {16'd0, r_max, r_min};
`ifdef FRAME_STATS_THRESHOLD_EN
        3'd7:    ciResult = {12'd0, r_count};
`endif
        default: ciResult = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_addr      <= '0;
      r_sum       <= '0;
      r_addr_out  <= '0;
      r_words     <= '0;
      r_remaining <= '0;
      r_min       <= 8'hFF;
      r_max       <= '0;
      r_burst_out <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_begin     <= 1'b0;
`ifdef FRAME_STATS_THRESHOLD_EN
      r_thresh    <= '0;
      r_count     <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_begin     <= (r_state == StInit);
      r_addr_out  <= (r_state == StInit) ? r_addr : 32'd0;
      r_burst_out <= (r_state == StInit) ? ({3'b000, w_burst} - 8'd1) : 8'd0;
      if (w_wr) begin
        case (w_cmd)
          3'd0: r_base  <= {ciValueB[31:2], 2'b00};
          3'd1: r_words <= ciValueB[17:0];
`ifdef FRAME_STATS_THRESHOLD_EN
          3'd2: r_thresh <= ciValueB[7:0];
`endif
          3'd3: begin
            r_sum       <= '0;
            r_min       <= 8'hFF;
            r_max       <= '0;
`ifdef FRAME_STATS_THRESHOLD_EN
            r_count     <= '0;
`endif
            r_error     <= 1'b0;
            r_done      <= (r_words == '0);
            r_busy      <= (r_words != '0);
            r_addr      <= r_base;
            r_remaining <= r_words;
          end
          default: ;
        endcase
      end
      if (r_state == StInit) begin
        r_remaining <= r_remaining - {13'd0, w_burst};
        r_addr      <= r_addr + {25'd0, w_burst, 2'b00};
      end
      if (w_accum) begin
        r_sum <= r_sum + {22'd0, w_word_sum};
        if (w_word_min < r_min) r_min <= w_word_min;
        if (w_word_max > r_max) r_max <= w_word_max;
`ifdef FRAME_STATS_THRESHOLD_EN
        r_count <= r_count + {17'd0, w_word_cnt};
`endif
      end
      if (r_state == StAbort) begin
        r_error <= 1'b1;
        r_busy  <= 1'b0;
      end
      if ((r_state == StNext) && (r_remaining == '0)) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_stats_reader.sv
// Self-checking bench for frame_stats_reader: a bus-slave model serves a word array and a
// pixel-level reference model predicts the statistics read back over the custom instruction.
`timescale 1ns/1ps
module tb_frame_stats_reader;
  localparam logic [7:0] CiId = 8'd0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ciStart = 1'b0, ciCke = 1'b0;
  logic [7:0]  ciN = 8'd0;
  logic [31:0] ciValueA = '0, ciValueB = '0;
  logic [31:0] ciResult;
  logic        ciDone;
  logic        requestBus;
  logic        busGrant = 1'b0;
  logic        beginTransactionOut;
  logic [31:0] addressDataOut;
  logic        readNotWriteOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic        endTransactionOut;
  logic [31:0] addressDataIn = '0;
  logic        dataValidIn = 1'b0, endTransactionIn = 1'b0, busErrorIn = 1'b0;

  frame_stats_reader #(.customInstructionId(CiId)) dut (
    .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
    .ciValueA(ciValueA), .ciValueB(ciValueB), .ciResult(ciResult), .ciDone(ciDone),
    .requestBus(requestBus), .busGrant(busGrant), .beginTransactionOut(beginTransactionOut),
    .addressDataOut(addressDataOut), .readNotWriteOut(readNotWriteOut),
    .byteEnablesOut(byteEnablesOut), .burstSizeOut(burstSizeOut),
    .endTransactionOut(endTransactionOut), .addressDataIn(addressDataIn),
    .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem [0:63];
  int unsigned exp_sum;
  int          exp_min, exp_max, exp_cnt;
  logic [7:0]  exp_thr;
  logic [31:0] rd;

  task automatic ci_op(input logic [2:0] cmd, input logic [31:0] val, output logic [31:0] res);
    @(negedge clock);
    ciStart = 1'b1; ciCke = 1'b1; ciN = CiId; ciValueA = {29'd0, cmd}; ciValueB = val;
    #1 res = ciResult;
    @(posedge clock);
    #1 ciStart = 1'b0; ciCke = 1'b0;
  endtask

  task automatic model_clear();
    exp_sum = 0; exp_min = 255; exp_max = 0; exp_cnt = 0;
  endtask

  task automatic model_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      int p;
      p = int'(w[8*b +: 8]);
      exp_sum += p;
      if (p < exp_min) exp_min = p;
      if (p > exp_max) exp_max = p;
      if (p > int'(exp_thr)) exp_cnt++;
    end
  endtask

  function automatic logic [31:0] exp_mm();
    return {16'd0, exp_max[7:0], exp_min[7:0]};
  endfunction

  function automatic logic [31:0] exp_c7();
`ifdef FRAME_STATS_THRESHOLD_EN
    return {12'd0, exp_cnt[19:0]};
`else
    return 32'd0;
`endif
  endfunction

  task automatic start_run(input logic [31:0] base_a, input int n, input logic [7:0] thr);
    ci_op(3'd0, base_a, rd);
    ci_op(3'd1, 32'(n), rd);
    ci_op(3'd2, {24'd0, thr}, rd);
    exp_thr = thr;
    model_clear();
    ci_op(3'd3, 32'd0, rd);
  endtask

  // Bus slave: grants each request, checks the burst header, streams mem[] words.
  task automatic serve(input int n, input logic [31:0] base_a, input int err_idx);
    int          remaining = n;
    int          idx = 0;
    int          burst, waited;
    bit          abort = 0;
    logic [31:0] addr = base_a;
    while (remaining > 0 && !abort) begin
      waited = 0;
      @(negedge clock);
      while (requestBus !== 1'b1 && waited < 20) begin @(negedge clock); waited++; end
      n_checks++;
      if (requestBus !== 1'b1) begin
        n_errors++; $display("FAIL req_wait requestBus=%b expected 1", requestBus); return;
      end
      busGrant = 1'b1;
      @(negedge clock);
      busGrant = 1'b0;
      n_checks++;
      if (beginTransactionOut !== 1'b0) begin
        n_errors++; $display("FAIL begin_early begin=%b expected 0", beginTransactionOut);
      end
      @(negedge clock);
      burst = (remaining > 16) ? 16 : remaining;
      n_checks++;
      if ({beginTransactionOut, readNotWriteOut, byteEnablesOut, burstSizeOut, addressDataOut}
          !== {1'b1, 1'b1, 4'hF, 8'(burst - 1), addr}) begin
        n_errors++;
        $display("FAIL burst_hdr got beg=%b rnw=%b be=%h size=%0d addr=%h expected size=%0d addr=%h",
                 beginTransactionOut, readNotWriteOut, byteEnablesOut, burstSizeOut,
                 addressDataOut, burst - 1, addr);
      end
      for (int k = 0; k < burst; k++) begin
        if (k > 0) @(negedge clock);
        addressDataIn = mem[idx];
        dataValidIn = 1'b1;
        if (idx == err_idx) begin busErrorIn = 1'b1; abort = 1; break; end
        endTransactionIn = (k == burst - 1);
        model_word(mem[idx]);
        idx++;
      end
      @(negedge clock);
      dataValidIn = 1'b0; endTransactionIn = 1'b0; busErrorIn = 1'b0; addressDataIn = '0;
      n_checks++;
      if (endTransactionOut !== abort) begin
        n_errors++; $display("FAIL end_out endTransactionOut=%b expected %b", endTransactionOut, abort);
      end
      remaining -= burst;
      addr += 32'(4 * burst);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({requestBus, beginTransactionOut, addressDataOut, readNotWriteOut, byteEnablesOut,
         burstSizeOut, endTransactionOut, ciDone, ciResult} !== '0) begin
      n_errors++; $display("FAIL reset_outputs req=%b beg=%b addr=%h size=%h expected all 0",
                           requestBus, beginTransactionOut, addressDataOut, burstSizeOut);
    end
    reset = 1'b0;
    ci_op(3'd4, 0, rd);
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL reset_status got %h expected 0", rd); end
    ci_op(3'd5, 0, rd);
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL reset_sum got %h expected 0", rd); end
    ci_op(3'd6, 0, rd);
    n_checks++; if (rd !== 32'hFF) begin n_errors++; $display("FAIL reset_minmax got %h expected ff", rd); end
    ci_op(3'd7, 0, rd);
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL reset_count got %h expected 0", rd); end
    @(negedge clock);
    ciStart = 1'b1; ciCke = 1'b1; ciN = 8'h05; ciValueA = 32'd6;
    #1;
    n_checks++;
    if ({ciDone, ciResult} !== '0) begin
      n_errors++; $display("FAIL wrong_ci done=%b result=%h expected 0/0", ciDone, ciResult);
    end
    @(posedge clock);
    #1 ciStart = 1'b0; ciCke = 1'b0; ciN = CiId;
  endtask

  task automatic test_directed();
    mem[0] = 32'h04030201; mem[1] = 32'h08070605; mem[2] = 32'hFF000010; mem[3] = 32'h80808080;
    start_run(32'h1000, 4, 8'h7F);
    n_checks++;
    if (requestBus !== 1'b1) begin n_errors++; $display("FAIL start_to_req got %b expected 1", requestBus); end
    serve(4, 32'h1000, -1);
    ci_op(3'd4, 0, rd);
    n_checks++; if (rd !== 32'd2) begin n_errors++; $display("FAIL dir_status got %h expected 2", rd); end
    ci_op(3'd5, 0, rd);
    n_checks++; if (rd !== exp_sum) begin n_errors++; $display("FAIL dir_sum got %h expected %h", rd, exp_sum); end
    ci_op(3'd6, 0, rd);
    n_checks++; if (rd !== exp_mm()) begin n_errors++; $display("FAIL dir_minmax got %h expected %h", rd, exp_mm()); end
    ci_op(3'd7, 0, rd);
    n_checks++; if (rd !== exp_c7()) begin n_errors++; $display("FAIL dir_count got %h expected %h", rd, exp_c7()); end
  endtask

  task automatic test_multi_burst();
    logic [31:0] base_a;
    base_a = $urandom & 32'hFFFF_FFFC;
    for (int i = 0; i < 40; i++) mem[i] = 32'h01010101;
    start_run(base_a, 40, 8'h00);
    serve(40, base_a, -1);
    ci_op(3'd5, 0, rd);
    n_checks++; if (rd !== 32'd160) begin n_errors++; $display("FAIL multi_sum got %0d expected 160", rd); end
    ci_op(3'd4, 0, rd);
    n_checks++; if (rd !== 32'd2) begin n_errors++; $display("FAIL multi_status got %h expected 2", rd); end
  endtask

  task automatic test_zero_count();
    bit saw_req = 0;
    start_run(32'h3000, 0, 8'h10);
    ci_op(3'd4, 0, rd);
    n_checks++; if (rd !== 32'd2) begin n_errors++; $display("FAIL zero_status got %h expected 2", rd); end
    repeat (4) begin @(negedge clock); if (requestBus !== 1'b0) saw_req = 1; end
    n_checks++; if (saw_req) begin n_errors++; $display("FAIL zero_req got 1 expected 0"); end
    ci_op(3'd6, 0, rd);
    n_checks++; if (rd !== 32'hFF) begin n_errors++; $display("FAIL zero_minmax got %h expected ff", rd); end
    ci_op(3'd5, 0, rd);
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL zero_sum got %h expected 0", rd); end
  endtask

  task automatic test_bus_error();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    start_run(32'h5000, 16, 8'($urandom));
    serve(16, 32'h5000, 2);
    ci_op(3'd4, 0, rd);
    n_checks++; if (rd !== 32'd4) begin n_errors++; $display("FAIL err_status got %h expected 4", rd); end
    ci_op(3'd5, 0, rd);
    n_checks++; if (rd !== exp_sum) begin n_errors++; $display("FAIL err_sum got %h expected %h", rd, exp_sum); end
    ci_op(3'd6, 0, rd);
    n_checks++; if (rd !== exp_mm()) begin n_errors++; $display("FAIL err_minmax got %h expected %h", rd, exp_mm()); end
    ci_op(3'd7, 0, rd);
    n_checks++; if (rd !== exp_c7()) begin n_errors++; $display("FAIL err_count got %h expected %h", rd, exp_c7()); end
  endtask

  task automatic test_busy_ignore();
    for (int i = 0; i < 20; i++) mem[i] = $urandom;
    start_run(32'h4000, 20, 8'h40);
    ci_op(3'd4, 0, rd);
    n_checks++; if (rd !== 32'd1) begin n_errors++; $display("FAIL busy_status got %h expected 1", rd); end
    ci_op(3'd0, 32'hDEAD0000, rd);
    ci_op(3'd1, 32'd5, rd);
    ci_op(3'd2, 32'hF0, rd);
    ci_op(3'd3, 32'd0, rd);
    serve(20, 32'h4000, -1);
    ci_op(3'd4, 0, rd);
    n_checks++; if (rd !== 32'd2) begin n_errors++; $display("FAIL busy_done got %h expected 2", rd); end
    ci_op(3'd5, 0, rd);
    n_checks++; if (rd !== exp_sum) begin n_errors++; $display("FAIL busy_sum got %h expected %h", rd, exp_sum); end
    ci_op(3'd7, 0, rd);
    n_checks++; if (rd !== exp_c7()) begin n_errors++; $display("FAIL busy_count got %h expected %h", rd, exp_c7()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int          n;
      logic [31:0] base_a;
      n = $urandom_range(1, 60);
      base_a = $urandom & 32'hFFFF_FFFC;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      start_run(base_a, n, 8'($urandom));
      serve(n, base_a, -1);
      ci_op(3'd5, 0, rd);
      n_checks++; if (rd !== exp_sum) begin n_errors++; $display("FAIL rnd_sum[%0d] got %h expected %h", it, rd, exp_sum); end
      ci_op(3'd6, 0, rd);
      n_checks++; if (rd !== exp_mm()) begin n_errors++; $display("FAIL rnd_minmax[%0d] got %h expected %h", it, rd, exp_mm()); end
      ci_op(3'd7, 0, rd);
      n_checks++; if (rd !== exp_c7()) begin n_errors++; $display("FAIL rnd_count[%0d] got %h expected %h", it, rd, exp_c7()); end
    end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    start_run(32'h8000, 16, 8'h00);
    @(negedge clock);
    while (requestBus !== 1'b1 && waited < 20) begin @(negedge clock); waited++; end
    busGrant = 1'b1;
    @(negedge clock); busGrant = 1'b0;
    @(negedge clock);
    dataValidIn = 1'b1; addressDataIn = 32'h11223344;
    @(negedge clock);
    addressDataIn = 32'h55667788;
    @(negedge clock);
    dataValidIn = 1'b0; addressDataIn = '0;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({requestBus, beginTransactionOut, addressDataOut, readNotWriteOut, byteEnablesOut,
         burstSizeOut, endTransactionOut} !== '0) begin
      n_errors++; $display("FAIL mid_reset_outputs req=%b beg=%b addr=%h expected all 0",
                           requestBus, beginTransactionOut, addressDataOut);
    end
    @(negedge clock);
    reset = 1'b0;
    ci_op(3'd4, 0, rd);
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL mid_status got %h expected 0", rd); end
    ci_op(3'd5, 0, rd);
    n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL mid_sum got %h expected 0", rd); end
    mem[0] = $urandom; mem[1] = $urandom; mem[2] = $urandom;
    start_run(32'h9000, 3, 8'h80);
    serve(3, 32'h9000, -1);
    ci_op(3'd4, 0, rd);
    n_checks++; if (rd !== 32'd2) begin n_errors++; $display("FAIL fresh_status got %h expected 2", rd); end
    ci_op(3'd5, 0, rd);
    n_checks++; if (rd !== exp_sum) begin n_errors++; $display("FAIL fresh_sum got %h expected %h", rd, exp_sum); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_multi_burst();
    test_zero_count();
    test_bus_error();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
